// File: rtl/csa_double_bist_top.sv
// 7-bit self-repairing carry-select adder with BIST; five 2-bit blocks cover three positions.
// Optional FAULT_INJECT_EN adds fi_mask to force s0[0] stuck-at-1 per block.
module csa_double_bist_top #(
    parameter int PAT_LAST = 15
) (
    input  logic       clk,
    input  logic       init,
    input  logic       test,
    input  logic [6:0] x,
    input  logic [6:0] y,
    input  logic       cin,
`ifdef FAULT_INJECT_EN
    input  logic [4:0] fi_mask,
`endif
    output logic [6:0] sum,
    output logic       cout,
    output logic [3:0] test_data,
    output logic [4:0] comp,
    output logic       test_done,
    output logic       map_err
);

    logic [3:0]      r_cnt;
    logic [4:0]      r_comp;
    logic            r_done;
    logic [2:0][2:0] r_map;
    logic            r_map_err;

    logic [4:0]      w_fi;
    logic [2:0][2:0] w_map;
    logic            w_map_err;
    logic [2:0]      w_n;
    logic [2:0]      w_good;
    logic [4:0][1:0] w_a;
    logic [4:0][1:0] w_b;
    logic [4:0][5:0] w_resp;
    logic [4:0]      w_match;
    logic [2:0]      w_tsum;
    logic [5:0]      w_desired;
    logic [2:0][1:0] w_xp;
    logic [2:0][1:0] w_yp;
    logic [2:0][2:0] w_sel;
    logic [3:0]      w_c;
    logic [1:0]      w_bit0;

`ifdef FAULT_INJECT_EN
    assign w_fi = fi_mask;
`else
    assign w_fi = 5'b00000;
`endif

    assign w_xp = {x[6:5], x[4:3], x[2:1]};
    assign w_yp = {y[6:5], y[4:3], y[2:1]};

    // In normal mode each physical block sees the pair of the position it serves
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < 5; k++) begin
            if (test) begin
                w_a[k] = r_cnt[3:2];
                w_b[k] = r_cnt[1:0];
            end else begin
                for (int l = 0; l < 3; l++) begin
                    if (r_map[l] == 3'(k)) begin
                        w_a[k] = w_xp[l];
                        w_b[k] = w_yp[l];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_blk
        logic [2:0] w_s0;
        logic [2:0] w_s1;
        assign w_s0 = (3'(w_a[k]) + 3'(w_b[k])) | {2'b00, w_fi[k]};
        assign w_s1 = 3'(w_a[k]) + 3'(w_b[k]) + 3'd1;
        assign w_resp[k] = {w_s1, w_s0};
        assign w_match[k] = (w_resp[k] == w_desired);
    end

    assign w_tsum = 3'(r_cnt[3:2]) + 3'(r_cnt[1:0]);
    assign w_desired = {w_tsum + 3'd1, w_tsum};

    // Passing blocks fill positions first, then the lowest failed ones
    always_comb begin
        w_map = '0;
        w_n = '0;
        for (int k = 0; k < 5; k++) begin
            if (r_comp[k]) begin
                if (w_n < 3'd3) w_map[w_n[1:0]] = 3'(k);
                w_n = w_n + 3'd1;
            end
        end
        w_good = w_n;
        for (int k = 0; k < 5; k++) begin
            if (!r_comp[k]) begin
                if (w_n < 3'd3) w_map[w_n[1:0]] = 3'(k);
                w_n = w_n + 3'd1;
            end
        end
        w_map_err = (w_good < 3'd3);
    end

    assign w_bit0 = {1'b0, x[0]} + {1'b0, y[0]} + {1'b0, cin};
    assign w_c[0] = w_bit0[1];

    always_comb begin
        w_sel = '0;
        for (int l = 0; l < 3; l++) begin
            w_sel[l] = w_c[l] ? w_resp[r_map[l]][5:3] : w_resp[r_map[l]][2:0];
        end
    end

    assign w_c[1] = w_sel[0][2];
    assign w_c[2] = w_sel[1][2];
    assign w_c[3] = w_sel[2][2];

    assign sum  = test ? 7'd0 :
                  {w_sel[2][1:0], w_sel[1][1:0], w_sel[0][1:0], w_bit0[0]};
    assign cout = test ? 1'b0 : w_c[3];

    always_ff @(posedge clk) begin
        if (init) begin
            r_cnt     <= '0;
            r_comp    <= 5'b11111;
            r_done    <= 1'b0;
            r_map     <= {3'd2, 3'd1, 3'd0};
            r_map_err <= 1'b0;
        end else begin
            r_map     <= w_map;
            r_map_err <= w_map_err;
            if (test && !r_done) begin
                r_comp <= r_comp & w_match;
                if (r_cnt == 4'(PAT_LAST)) r_done <= 1'b1;
                else r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign test_data = r_cnt;
    assign comp      = r_comp;
    assign test_done = r_done;
    assign map_err   = r_map_err;

endmodule

// File: tb/tb_csa_double_bist_top.sv
// Self-checking bench for csa_double_bist_top: random stimulus against an
// arithmetic reference model of the BIST sequence and repaired adder.
module tb_csa_double_bist_top;

    logic       clk = 1'b0;
    logic       init, test, cin;
    logic [6:0] x, y;
    logic [6:0] sum;
    logic       cout;
    logic [3:0] test_data;
    logic [4:0] comp;
    logic       test_done, map_err;
`ifdef FAULT_INJECT_EN
    logic [4:0] fi_mask;
`endif

    int errors = 0;
    int checks = 0;

    int         m_cnt;
    bit         m_done;
    logic [4:0] m_comp;
    logic [4:0] m_mask;

    always #5 clk = ~clk;

    csa_double_bist_top dut (
        .clk(clk),
        .init(init),
        .test(test),
        .x(x),
        .y(y),
        .cin(cin),
`ifdef FAULT_INJECT_EN
        .fi_mask(fi_mask),
`endif
        .sum(sum),
        .cout(cout),
        .test_data(test_data),
        .comp(comp),
        .test_done(test_done),
        .map_err(map_err)
    );

    function automatic logic [7:0] ref_add(input logic [6:0] a, input logic [6:0] b,
                                           input logic ci, input logic [4:0] good,
                                           input logic [4:0] mask);
        int order[$];
        int c, r, pa, pb;
        logic [7:0] res;
        res = '0;
        for (int k = 0; k < 5; k++) if (good[k]) order.push_back(k);
        for (int k = 0; k < 5; k++) if (!good[k]) order.push_back(k);
        r = int'(a[0]) + int'(b[0]) + int'(ci);
        res[0] = (r % 2) != 0;
        c = r / 2;
        for (int l = 0; l < 3; l++) begin
            pa = (int'(a) >> (2 * l + 1)) & 3;
            pb = (int'(b) >> (2 * l + 1)) & 3;
            r = pa + pb + c;
            if (mask[order[l]] && c == 0) r = r | 1;
            res[2 * l + 1] = (r & 1) != 0;
            res[2 * l + 2] = (r & 2) != 0;
            c = r / 4;
        end
        res[7] = c != 0;
        return res;
    endfunction

    function automatic int popcount5(input logic [4:0] v);
        int n = 0;
        for (int k = 0; k < 5; k++) if (v[k]) n++;
        return n;
    endfunction

    task automatic model_step();
        int a, b;
        a = m_cnt / 4;
        b = m_cnt % 4;
        for (int k = 0; k < 5; k++)
            if (m_mask[k] && ((a + b) % 2 == 0)) m_comp[k] = 1'b0;
        if (m_cnt == 15) m_done = 1'b1;
        else m_cnt++;
    endtask

    task automatic do_init();
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        m_cnt = 0;
        m_done = 1'b0;
        m_comp = 5'b11111;
    endtask

    task automatic test_reset();
        test = 1'b1;
        x = 7'h55;
        y = 7'h2A;
        cin = 1'b1;
        do_init();
        checks++;
        if (test_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0h expected 0", test_data);
        end
        checks++;
        if (comp !== 5'b11111) begin
            errors++;
            $display("FAIL reset_comp: got %b expected 11111", comp);
        end
        checks++;
        if (test_done !== 1'b0 || map_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b err=%b expected 0 0", test_done, map_err);
        end
        checks++;
        if (sum !== 7'd0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_testmode_sum: got %0h/%b expected 0/0", sum, cout);
        end
        test = 1'b0;
    endtask

    task automatic test_selftest();
        bit t;
        int budget = 0;
        while (!m_done && budget < 200) begin
            t = ($urandom_range(0, 3) != 0);
            test = t;
            x = 7'($urandom);
            y = 7'($urandom);
            cin = 1'($urandom);
            if (t && !m_done) model_step();
            @(posedge clk);
            #1;
            budget++;
            checks++;
            if (test_data !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL tpg_cnt: got %0d expected %0d", test_data, m_cnt);
            end
            checks++;
            if (comp !== m_comp || test_done !== m_done) begin
                errors++;
                $display("FAIL tpg_state: got comp=%b done=%b expected %b %b",
                         comp, test_done, m_comp, m_done);
            end
            if (t) begin
                checks++;
                if (sum !== 7'd0 || cout !== 1'b0) begin
                    errors++;
                    $display("FAIL test_sum_zero: got %0h/%b expected 0/0", sum, cout);
                end
            end
        end
        checks++;
        if (!m_done) begin
            errors++;
            $display("FAIL selftest_timeout: got done=%b expected 1", test_done);
        end
        test = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (test_data !== 4'd15 || comp !== m_comp || test_done !== 1'b1) begin
            errors++;
            $display("FAIL post_done_hold: got cnt=%0d comp=%b done=%b expected 15 %b 1",
                     test_data, comp, test_done, m_comp);
        end
        checks++;
        if (map_err !== (popcount5(m_comp) < 3)) begin
            errors++;
            $display("FAIL map_err: got %b expected %b", map_err, popcount5(m_comp) < 3);
        end
        test = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_directed();
        test = 1'b0;
        x = 7'd6;
        y = 7'd5;
        cin = 1'b0;
        #1;
        checks++;
        if ({cout, sum} !== 8'd11) begin
            errors++;
            $display("FAIL add_6_5: got %0d expected 11", {cout, sum});
        end
        x = 7'b1010101;
        y = 7'b0101010;
        #1;
        checks++;
        if (sum !== 7'h7F || cout !== 1'b0) begin
            errors++;
            $display("FAIL add_alt_c0: got %0h/%b expected 7f/0", sum, cout);
        end
        cin = 1'b1;
        #1;
        checks++;
        if (sum !== 7'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL add_alt_c1: got %0h/%b expected 0/1", sum, cout);
        end
    endtask

    task automatic test_add_random();
        logic [7:0] exp;
        test = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            x = 7'($urandom);
            y = 7'($urandom);
            cin = 1'($urandom);
            #1;
            exp = ref_add(x, y, cin, m_comp, m_mask);
            checks++;
            if ({cout, sum} !== exp) begin
                errors++;
                $display("FAIL add_rand: x=%0h y=%0h cin=%b got %0h expected %0h",
                         x, y, cin, {cout, sum}, exp);
            end
        end
    endtask

    task automatic test_init_abort();
        do_init();
        test = 1'b1;
        for (int i = 0; i < 8; i++) begin
            model_step();
            @(posedge clk);
        end
        #1;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        m_cnt = 0;
        m_done = 1'b0;
        m_comp = 5'b11111;
        checks++;
        if (test_data !== 4'd0 || comp !== 5'b11111 || test_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got cnt=%0d comp=%b done=%b expected 0 11111 0",
                     test_data, comp, test_done);
        end
        for (int i = 0; i < 15; i++) begin
            model_step();
            @(posedge clk);
        end
        #1;
        checks++;
        if (test_done !== 1'b0 || test_data !== 4'd15) begin
            errors++;
            $display("FAIL abort_rerun_15: got done=%b cnt=%0d expected 0 15", test_done, test_data);
        end
        model_step();
        @(posedge clk);
        #1;
        checks++;
        if (test_done !== 1'b1 || comp !== m_comp) begin
            errors++;
            $display("FAIL abort_rerun_16: got done=%b comp=%b expected 1 %b",
                     test_done, comp, m_comp);
        end
        test = 1'b0;
        @(posedge clk);
        #1;
    endtask

`ifdef FAULT_INJECT_EN
    task automatic test_fault_two();
        fi_mask = 5'b00101;
        m_mask = 5'b00101;
        do_init();
        test_selftest();
        checks++;
        if (comp !== 5'b11010 || map_err !== 1'b0) begin
            errors++;
            $display("FAIL fault2_comp: got %b err=%b expected 11010 0", comp, map_err);
        end
        test_add_directed();
        test_add_random();
    endtask

    task automatic test_fault_three();
        fi_mask = 5'b00111;
        m_mask = 5'b00111;
        do_init();
        test_selftest();
        checks++;
        if (comp !== 5'b11000 || map_err !== 1'b1) begin
            errors++;
            $display("FAIL fault3_comp: got %b err=%b expected 11000 1", comp, map_err);
        end
        test_add_random();
    endtask
`endif

    initial begin
        init = 1'b0;
        test = 1'b0;
        x = '0;
        y = '0;
        cin = 1'b0;
        m_mask = 5'b00000;
`ifdef FAULT_INJECT_EN
        fi_mask = 5'b00000;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_selftest();
        test_add_directed();
        test_add_random();
        test_init_abort();
        test_add_random();
`ifdef FAULT_INJECT_EN
        test_fault_two();
        test_fault_three();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
